// File: rtl/posit_field_extract.sv
// Posit field extractor: a two-stage valid/ready pipeline that splits a posit word
// into sign, zero/NaR flags, signed scale k*2^ES+e and an MSB-aligned fraction.
module posit_field_extract #(
   parameter int N       = 16,
   parameter int ES      = 1,
   parameter int RUN_W   = $clog2(N),
   parameter int SCALE_W = $clog2(N) + ES + 2,
   parameter int FRAC_W  = N - 3 - ES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_posit,
   input  logic [RUN_W-1:0]   in_run,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sign,
   output logic               out_zero,
   output logic               out_nar,
   output logic [SCALE_W-1:0] out_scale,
   output logic [FRAC_W-1:0]  out_frac
);

   localparam int STAGES = 2;

   // Stage 1 keeps only the body bits below the first two regime positions:
   // the shift always discards at least the leading regime bit and its terminator.
   typedef struct packed {
      logic             sign;
      logic             zero;
      logic             nar;
      logic             rb;
      logic [RUN_W-1:0] run;
      logic [N-4:0]     low;
   } s1_t;

   typedef struct packed {
      logic               sign;
      logic               zero;
      logic               nar;
      logic [SCALE_W-1:0] scale;
      logic [FRAC_W-1:0]  frac;
   } out_t;

   logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
   s1_t                s1_q, s1_d;
   out_t               out_q, out_d;
   logic               stage1_en, stage2_en;
   logic [N-1:0]       mag;
   logic [N-4:0]       ef;
   logic [SCALE_W-1:0] run_ext, e_ext, k;

   assign stage2_en = !vld_pipe_q[2] || out_ready;
   assign stage1_en = !vld_pipe_q[1] || stage2_en;
   assign in_ready  = stage1_en;

   always_comb begin
      mag        = in_posit[N-1] ? -in_posit : in_posit;
      s1_d.sign  = in_posit[N-1];
      s1_d.zero  = (in_posit == '0);
      s1_d.nar   = (in_posit == {1'b1, {(N-1){1'b0}}});
      s1_d.rb    = mag[N-2];
      s1_d.low   = mag[N-4:0];
      if (in_run == '0)
         s1_d.run = RUN_W'(1);
      else if (in_run > RUN_W'(N-1))
         s1_d.run = RUN_W'(N-1);
      else
         s1_d.run = in_run;
   end

   // Shifting the low body by run-1 equals shifting the full body by run+1 and
   // dropping the two bits that fell off the top.
   always_comb begin
      run_ext     = SCALE_W'(s1_q.run);
      ef          = s1_q.low << (s1_q.run - RUN_W'(1));
      e_ext       = SCALE_W'(ef >> FRAC_W);
      k           = s1_q.rb ? run_ext - SCALE_W'(1) : SCALE_W'(0) - run_ext;
      out_d.sign  = s1_q.sign;
      out_d.zero  = s1_q.zero;
      out_d.nar   = s1_q.nar;
      out_d.scale = (k << ES) + e_ext;
      out_d.frac  = ef[FRAC_W-1:0];
      if (s1_q.zero || s1_q.nar) begin
         out_d.scale = '0;
         out_d.frac  = '0;
      end
   end

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      if (stage2_en) vld_pipe_d[2] = vld_pipe_q[1];
      if (stage1_en) vld_pipe_d[1] = in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         s1_q       <= '0;
         out_q      <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         if (stage1_en && in_valid)      s1_q  <= s1_d;
         if (stage2_en && vld_pipe_q[1]) out_q <= out_d;
      end
   end

   assign out_valid = vld_pipe_q[2];
   assign out_sign  = out_q.sign;
   assign out_zero  = out_q.zero;
   assign out_nar   = out_q.nar;
   assign out_scale = out_q.scale;
   assign out_frac  = out_q.frac;

endmodule
